// File: rtl/cache_mem_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------------
// | Module      : cache_mem_arbiter_if
// | Description : Cache-pair and memory-port bundle for the cache/memory arbiter.
// | Revision    : 1.0 - initial release
// +-----------------------------------------------------------------------------
interface cache_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
);
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [BEAT_W-1:0] mem_wdata;
  logic [BEAT_W-1:0] mem_rdata;
  logic              mem_resp;

  // The arbiter itself
  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_addr, mem_wdata
  );

  // The caches and memory surrounding it
  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/cache_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------------
// | Module      : cache_mem_arbiter
// | Description : Round-robin I/D line arbiter that splits each line into a
// |               BURSTS-beat memory burst through one shared line buffer.
// | Revision    : 1.0 - initial release
// +-----------------------------------------------------------------------------
module cache_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64,
  parameter int BURSTS = 4
) (
  input logic                clk,
  input logic                rst,
  cache_mem_arbiter_if.slave bus
);

  localparam int OFF_W   = $clog2(LINE_W / 8);
  localparam int BEAT_CW = (BURSTS > 1) ? $clog2(BURSTS) : 1;
  localparam logic [BEAT_CW-1:0] LAST_BEAT = BEAT_CW'(BURSTS - 1);

  if (LINE_W != BURSTS * BEAT_W) begin : g_bad_geometry
    $error("cache_mem_arbiter: LINE_W must equal BURSTS * BEAT_W");
  end

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_I_RD = 3'd1,
    S_D_RD = 3'd2,
    S_D_WR = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [BEAT_CW-1:0] r_beat;
  logic               r_last_d;
  logic               r_serve_d;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [LINE_W-1:0]  r_line;

  logic              w_want_i;
  logic              w_want_d;
  logic              w_pick_d;
  logic              w_grant;
  logic              w_busy;
  logic              w_beat_ack;
  logic              w_last_ack;
  logic [ADDR_W-1:0] w_sel_addr;
  logic              w_unused_offset;
  logic              w_mem_read;
  logic              w_mem_write;
  logic              w_i_resp;
  logic              w_d_resp;

  assign w_want_i   = bus.i_read;
  assign w_want_d   = bus.d_read | bus.d_write;
  // On contention the side that did not win last time takes the grant.
  assign w_pick_d   = w_want_d & (~w_want_i | ~r_last_d);
  assign w_grant    = (r_state == S_IDLE) & (w_want_i | w_want_d);
  assign w_busy     = (r_state == S_I_RD) | (r_state == S_D_RD) | (r_state == S_D_WR);
  assign w_beat_ack = w_busy & bus.mem_resp;
  assign w_last_ack = w_beat_ack & (r_beat == LAST_BEAT);
  assign w_sel_addr = w_pick_d ? bus.d_addr : bus.i_addr;
  assign w_unused_offset = ^w_sel_addr[OFF_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_i_resp    = 1'b0;
    w_d_resp    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          if (!w_pick_d)        w_state_nxt = S_I_RD;
          else if (bus.d_write) w_state_nxt = S_D_WR;
          else                  w_state_nxt = S_D_RD;
        end
      end
      S_I_RD, S_D_RD: begin
        w_mem_read = 1'b1;
        if (w_last_ack) w_state_nxt = S_DONE;
      end
      S_D_WR: begin
        w_mem_write = 1'b1;
        if (w_last_ack) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_i_resp    = ~r_serve_d;
        w_d_resp    = r_serve_d;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_beat     <= '0;
      r_last_d   <= 1'b0;
      r_serve_d  <= 1'b0;
      r_mem_addr <= '0;
      r_line     <= '0;
    end else begin
      if (w_grant) begin
        r_serve_d  <= w_pick_d;
        r_last_d   <= w_pick_d;
        r_mem_addr <= {w_sel_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        if (w_pick_d && bus.d_write) r_line <= bus.d_wdata;
      end
      if (w_beat_ack) begin
        if (r_state != S_D_WR) r_line[r_beat*BEAT_W +: BEAT_W] <= bus.mem_rdata;
        r_beat <= w_last_ack ? '0 : r_beat + 1'b1;
      end
    end
  end

  assign bus.mem_read  = w_mem_read;
  assign bus.mem_write = w_mem_write;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_line[r_beat*BEAT_W +: BEAT_W];
  assign bus.i_resp    = w_i_resp;
  assign bus.d_resp    = w_d_resp;
  assign bus.i_rdata   = r_line;
  assign bus.d_rdata   = r_line;

  a_d_rw_exclusive: assert property (@(posedge clk) disable iff (!rst)
    (r_state == S_IDLE) |-> !(bus.d_read && bus.d_write));
  a_no_stray_resp: assert property (@(posedge clk) disable iff (!rst)
    ((r_state == S_IDLE) || (r_state == S_DONE)) |-> !bus.mem_resp);

endmodule
`default_nettype wire
